systolic_feeder: RTL and testbench

Operand transmitter for the output-stationary MAC array. It buffers one N×N A tile and one N×N B tile. On command it streams them into the array's `new_a_column` / `new_b_row` inputs with the diagonal skew the array expects, then flushes zeros so the last operands reach every PE. It is the producing end of the array's operand interface and sits between the tile loader and the MAC array manager.

---
 rtl/systolic_feeder.sv | 160 ++++++++++++++++
 tb/tb_systolic_feeder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - buffers one A/B tile and streams it diagonally skewed into the MAC array
// Optional SYSTOLIC_FEEDER_DOUBLE_BUF_EN: second tile bank so the next tile loads while this one streams.
module systolic_feeder #(
  parameter int N        = 2,
  parameter int OP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [N*OP_WIDTH-1:0] load_a_row,
  input  logic [N*OP_WIDTH-1:0] load_b_col,
  input  logic                  start,
  output logic                  busy,
  output logic                  acc_clear,
  output logic [N*OP_WIDTH-1:0] new_a_column,
  output logic [N*OP_WIDTH-1:0] new_b_row,
  output logic                  done
);
  localparam int SW = $clog2(2*N);
  localparam int CW = $clog2(N+1);
  localparam int IW = $clog2(N);
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STREAM, S_FLUSH} state_t;

  state_t              r_state, w_nxt_state;
  logic [SW-1:0]       r_step, w_nxt_step;
  logic [CW-1:0]       r_ld_cnt, w_nxt_ld_cnt;
  logic [OP_WIDTH-1:0] r_a [NB][N][N];
  logic [OP_WIDTH-1:0] r_b [NB][N][N];
  logic                r_load_ready, r_acc_clear, r_done;
  logic [N*OP_WIDTH-1:0] r_a_bus, r_b_bus, w_a_bus, w_b_bus;
  logic                w_full, w_accept, w_load_fire, w_nxt_ready;
  logic                w_ld_bank, w_st_bank;

  assign w_full      = (r_ld_cnt == CW'(N));
  assign w_accept    = (r_state == S_IDLE) && start && w_full;
  assign w_load_fire = load_valid && r_load_ready;

`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
  logic r_sel;  // bank currently owned by the stream side
  assign w_st_bank = r_sel;
  assign w_ld_bank = ~r_sel;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_sel <= 1'b0;
    else if (w_accept) r_sel <= ~r_sel;
  end
`else
  assign w_st_bank = 1'b0;
  assign w_ld_bank = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_step   <= '0;
      r_ld_cnt <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_step   <= w_nxt_step;
      r_ld_cnt <= w_nxt_ld_cnt;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_step  = r_step;
    case (r_state)
      S_IDLE:   if (w_accept) w_nxt_state = S_CLEAR;
      S_CLEAR: begin
        w_nxt_state = S_STREAM;
        w_nxt_step  = '0;
      end
      S_STREAM: begin
        if (r_step == SW'(2*N-2)) begin
          w_nxt_state = S_FLUSH;
          w_nxt_step  = '0;
        end else begin
          w_nxt_step = r_step + 1'b1;
        end
      end
      S_FLUSH: begin
        if (r_step == SW'(N-1)) begin
          w_nxt_state = S_IDLE;
          w_nxt_step  = '0;
        end else begin
          w_nxt_step = r_step + 1'b1;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_nxt_ld_cnt = r_ld_cnt;
    if (w_load_fire) w_nxt_ld_cnt = r_ld_cnt + 1'b1;
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
    if (w_accept) w_nxt_ld_cnt = '0;
    w_nxt_ready = (w_nxt_ld_cnt != CW'(N));
`else
    if (r_state == S_FLUSH && w_nxt_state == S_IDLE) w_nxt_ld_cnt = '0;
    w_nxt_ready = (w_nxt_ld_cnt != CW'(N)) && (w_nxt_state == S_IDLE);
`endif
  end

  // Beat k is row k of A and column k of B
  always_ff @(posedge clk) begin
    if (w_load_fire) begin
      for (int c = 0; c < N; c++) begin
        r_a[w_ld_bank][r_ld_cnt[IW-1:0]][c] <= load_a_row[c*OP_WIDTH +: OP_WIDTH];
        r_b[w_ld_bank][c][r_ld_cnt[IW-1:0]] <= load_b_col[c*OP_WIDTH +: OP_WIDTH];
      end
    end
  end

  // Lane i carries element k of its row/column when step == i + k
  always_comb begin
    w_a_bus = '0;
    w_b_bus = '0;
    if (w_nxt_state == S_STREAM) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (w_nxt_step == SW'(i + k)) begin
            w_a_bus[i*OP_WIDTH +: OP_WIDTH] = r_a[w_st_bank][i][k];
            w_b_bus[i*OP_WIDTH +: OP_WIDTH] = r_b[w_st_bank][k][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load_ready <= 1'b0;
      r_acc_clear  <= 1'b0;
      r_done       <= 1'b0;
      r_a_bus      <= '0;
      r_b_bus      <= '0;
    end else begin
      r_load_ready <= w_nxt_ready;
      r_acc_clear  <= (w_nxt_state == S_CLEAR);
      r_done       <= (r_state == S_FLUSH) && (w_nxt_state == S_IDLE);
      r_a_bus      <= w_a_bus;
      r_b_bus      <= w_b_bus;
    end
  end

  assign load_ready   = r_load_ready;
  assign busy         = (r_state != S_IDLE);
  assign acc_clear    = r_acc_clear;
  assign done         = r_done;
  assign new_a_column = r_a_bus;
  assign new_b_row    = r_b_bus;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - table-driven check of systolic_feeder skew, flush, load and reset behaviour
module tb_systolic_feeder;
  localparam int N  = 2;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [15:0]   load_a_row = '0;
  logic [15:0]   load_b_col = '0;
  logic          start = 1'b0;
  logic          busy, acc_clear, done;
  logic [15:0]   new_a_column, new_b_row;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        clr;
    logic        bsy;
    logic [15:0] a;
    logic [15:0] b;
    logic        dn;
  } vec_t;
  vec_t tbl [8];

  systolic_feeder #(.N(N), .OP_WIDTH(OW)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_a_row(load_a_row), .load_b_col(load_b_col),
    .start(start), .busy(busy), .acc_clear(acc_clear),
    .new_a_column(new_a_column), .new_b_row(new_b_row), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string name);
    chk({name, "_busy"}, 16'(busy), 16'd0);
    chk({name, "_clr"},  16'(acc_clear), 16'd0);
    chk({name, "_a"},    new_a_column, 16'h0000);
    chk({name, "_b"},    new_b_row, 16'h0000);
  endtask

  task automatic load_beat(input logic [15:0] a, input logic [15:0] b);
    chk("ready_before_beat", 16'(load_ready), 16'd1);
    load_valid = 1'b1;
    load_a_row = a;
    load_b_col = b;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic load_tile();
    load_beat(16'h0201, 16'h0705);
    load_beat(16'h0403, 16'h0806);
  endtask

  task automatic run_stream(input bit hold_load, input bit restart_flush);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      load_valid = hold_load && (c < 6);
      load_a_row = 16'hEEEE;
      load_b_col = 16'hDDDD;
      chk($sformatf("c%0d_clr", c + 1),  16'(acc_clear), 16'(tbl[c].clr));
      chk($sformatf("c%0d_busy", c + 1), 16'(busy), 16'(tbl[c].bsy));
      chk($sformatf("c%0d_a", c + 1),    new_a_column, tbl[c].a);
      chk($sformatf("c%0d_b", c + 1),    new_b_row, tbl[c].b);
      chk($sformatf("c%0d_done", c + 1), 16'(done), 16'(tbl[c].dn));
      if (hold_load && c < 6)
        chk($sformatf("c%0d_ready_busy", c + 1), 16'(load_ready), 16'd0);
      start = restart_flush && (c == 4);
      if (c == 6) load_valid = 1'b0;
      tick();
    end
    load_valid = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 16'h0001, 16'h0005, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 16'h0302, 16'h0607, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 16'h0400, 16'h0800, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};

    // Outputs held at zero during reset
    repeat (2) tick();
    chk("rst_ready", 16'(load_ready), 16'd0);
    chk("rst_done",  16'(done), 16'd0);
    chk_idle_zero("rst");
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 16'(load_ready), 16'd1);

    // Start with empty tile, then with a partial tile
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_idle_zero("start_empty");
    load_beat(16'h0201, 16'h0705);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_idle_zero("start_partial");

    // Final beat together with start: beat taken, start dropped
    load_valid = 1'b1;
    load_a_row = 16'h0403;
    load_b_col = 16'h0806;
    start = 1'b1;
    tick();
    load_valid = 1'b0;
    start = 1'b0;
    chk("full_ready", 16'(load_ready), 16'd0);
    tick();
    chk_idle_zero("start_with_last_beat");

`ifndef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
    run_stream(1'b1, 1'b0);
`else
    run_stream(1'b0, 1'b0);
`endif
    chk("after_done_ready", 16'(load_ready), 16'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_idle_zero("start_after_consume");

    // Reset during STREAM step 1
    load_tile();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_step1_a", new_a_column, 16'h0302);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 16'(load_ready), 16'd0);
    chk("mid_rst_done",  16'(done), 16'd0);
    chk_idle_zero("mid_rst");
    tick();
    reset = 1'b0;
    begin
      bit saw_done;
      saw_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (done) saw_done = 1'b1;
        tick();
      end
      chk("no_done_after_abort", 16'(saw_done), 16'd0);
    end
    chk("abort_ready", 16'(load_ready), 16'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_idle_zero("abort_cnt_cleared");
    load_tile();
    run_stream(1'b0, 1'b0);

    // Start pulsed during FLUSH is ignored
    load_tile();
    run_stream(1'b0, 1'b1);
    chk_idle_zero("post_flush_restart");

`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
    // Tile 2 loads during tile 1 streaming; start in the done cycle
    load_tile();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      load_valid = (c == 1) || (c == 2);
      load_a_row = 16'h1111;
      load_b_col = 16'h1111;
      tick();
    end
    load_valid = 1'b0;
    chk("db_done", 16'(done), 16'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("db_clr", 16'(acc_clear), 16'd1);
    tick();
    chk("db_step0_a", new_a_column, 16'h0011);
    chk("db_step0_b", new_b_row, 16'h0011);
    tick();
    chk("db_step1_a", new_a_column, 16'h1111);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
